// File: rtl/stepper_multi_pkg.sv
// Shared types and defaults for the multi-axis stepper pulse generator.
// Width defaults match the existing two-axis stepper.
package stepper_multi_pkg;

    localparam int DEF_NUM_AXES         = 3;
    localparam int DEF_PULSE_NUM_BITS   = 16;
    localparam int DEF_PULSE_WIDTH_BITS = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_HIGH   = 3'd2,
        ST_LOW    = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    // Signed to unsigned magnitude; the most negative value maps to 2^31.
    function automatic logic [31:0] abs_mag(input logic signed [31:0] v);
        logic [31:0] r;
        r = v[31] ? (~v + 32'd1) : v;
        return r;
    endfunction

endpackage

// File: rtl/stepper_axis_dda.sv
// One interpolated axis: latches magnitude/direction at move start and runs a
// DDA error accumulator that decides whether this axis pulses on each step.
module stepper_axis_dda
    import stepper_multi_pkg::*;
#(
    parameter int PULSE_NUM_BITS = DEF_PULSE_NUM_BITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_load,
    input  logic [PULSE_NUM_BITS-1:0] i_num,
    input  logic                      i_step,
    input  logic                      i_phase_end,
    input  logic [PULSE_NUM_BITS-1:0] i_major,
    output logic [PULSE_NUM_BITS-1:0] o_mag,
    output logic                      o_out,
    output logic                      o_dir
);

    // One extra bit so err + mag cannot wrap when both approach 2^(B-1).
    localparam int AW = PULSE_NUM_BITS + 1;

    logic [PULSE_NUM_BITS-1:0] w_mag_in;
    logic [PULSE_NUM_BITS-1:0] r_mag;
    logic [AW-1:0]             r_err;
    logic [AW-1:0]             w_sum;
    logic [AW-1:0]             w_major;
    logic                      r_out;
    logic                      r_dir;

    assign w_mag_in = PULSE_NUM_BITS'(abs_mag(32'($signed(i_num))));
    assign w_sum    = r_err + AW'(r_mag);
    assign w_major  = AW'(i_major);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mag <= '0;
            r_err <= '0;
            r_out <= 1'b0;
            r_dir <= 1'b1;
        end else if (i_load) begin
            r_mag <= w_mag_in;
            r_dir <= ~i_num[PULSE_NUM_BITS-1];
            r_err <= '0;
            r_out <= 1'b0;
        end else if (i_step) begin
            if (w_sum >= w_major) begin
                r_err <= w_sum - w_major;
                r_out <= 1'b1;
            end else begin
                r_err <= w_sum;
            end
        end else if (i_phase_end) begin
            r_out <= 1'b0;
        end
    end

    assign o_mag = r_mag;
    assign o_out = r_out;
    assign o_dir = r_dir;

endmodule

// File: rtl/stepper_ctrl_multi.sv
// N-axis stepper pulse generator: one trigger runs a linearly interpolated move
// where every axis finishes on the same major-axis step.
module stepper_ctrl_multi
    import stepper_multi_pkg::*;
#(
    parameter int NUM_AXES         = DEF_NUM_AXES,
    parameter int PULSE_NUM_BITS   = DEF_PULSE_NUM_BITS,
    parameter int PULSE_WIDTH_BITS = DEF_PULSE_WIDTH_BITS
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clk_en,
    input  logic                               trigger,
    input  logic                               abort,
    input  logic [PULSE_WIDTH_BITS-1:0]        pulse_width,
    input  logic [NUM_AXES*PULSE_NUM_BITS-1:0] pulse_num,
    output logic                               rdy,
    output logic                               done,
    output logic                               aborted,
    output logic [PULSE_NUM_BITS-1:0]          step_cnt,
    output logic [NUM_AXES-1:0]                out,
    output logic [NUM_AXES-1:0]                dir,
    output state_e                             dbg_state
);

    // Handshake: trigger is a level sampled on clk_en ticks in IDLE while rdy=1;
    // done falls on the accepting tick and rises when the move ends; trigger must
    // be seen low before another move (including after reset) is accepted.

    state_e                      r_state, w_next;
    logic                        r_rdy, r_done, r_aborted, r_armed;
    logic [PULSE_NUM_BITS-1:0]   r_step_cnt, w_cnt_inc, w_major;
    logic [PULSE_WIDTH_BITS-1:0] r_pw, r_wcnt, w_pw_eff;
    logic                        w_phase_done;
    logic                        w_accept, w_step, w_phase_end, w_abort, w_step_done;
    logic [PULSE_NUM_BITS-1:0]   w_mag [NUM_AXES];
    logic [NUM_AXES-1:0]         w_out, w_dir;

    assign w_pw_eff     = (r_pw == '0) ? PULSE_WIDTH_BITS'(1) : r_pw;
    assign w_phase_done = (r_wcnt == w_pw_eff - PULSE_WIDTH_BITS'(1));
    assign w_cnt_inc    = r_step_cnt + PULSE_NUM_BITS'(1);

    always_comb begin
        w_major = '0;
        for (int i = 0; i < NUM_AXES; i++) begin
            if (w_mag[i] > w_major) w_major = w_mag[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_phase_end = 1'b0;
        w_abort     = 1'b0;
        w_step_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clk_en && trigger && r_armed) begin
                    w_accept = 1'b1;
                    w_next   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (clk_en) begin
                    if (w_major == '0) begin
                        w_next = ST_FINISH;
                    end else begin
                        w_step = 1'b1;
                        w_next = ST_HIGH;
                    end
                end
            end
            ST_HIGH: begin
                if (clk_en) begin
                    if (abort) begin
                        w_abort     = 1'b1;
                        w_phase_end = 1'b1;
                        w_next      = ST_FINISH;
                    end else if (w_phase_done) begin
                        w_phase_end = 1'b1;
                        w_next      = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                if (clk_en) begin
                    if (abort) begin
                        w_abort     = 1'b1;
                        w_phase_end = 1'b1;
                        w_next      = ST_FINISH;
                    end else if (w_phase_done) begin
                        w_step_done = 1'b1;
                        if (w_cnt_inc == w_major) begin
                            w_next = ST_FINISH;
                        end else begin
                            w_step = 1'b1;
                            w_next = ST_HIGH;
                        end
                    end
                end
            end
            ST_FINISH: begin
                if (clk_en && !trigger) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdy      <= 1'b1;
            r_done     <= 1'b1;
            r_aborted  <= 1'b0;
            r_armed    <= 1'b0;
            r_step_cnt <= '0;
            r_pw       <= '0;
            r_wcnt     <= '0;
        end else if (clk_en) begin
            if (r_state == ST_IDLE && !trigger) r_armed <= 1'b1;
            // Phase counter restarts on every state change.
            r_wcnt <= (w_next != r_state) ? '0 : r_wcnt + PULSE_WIDTH_BITS'(1);
            if (w_accept) begin
                r_pw       <= pulse_width;
                r_rdy      <= 1'b0;
                r_done     <= 1'b0;
                r_aborted  <= 1'b0;
                r_step_cnt <= '0;
            end
            if (w_step_done) r_step_cnt <= w_cnt_inc;
            if (w_abort) r_aborted <= 1'b1;
            if (w_next == ST_FINISH && r_state != ST_FINISH) r_done <= 1'b1;
            if (w_next == ST_IDLE && r_state == ST_FINISH) r_rdy <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_AXES; g++) begin : g_axis
        stepper_axis_dda #(
            .PULSE_NUM_BITS(PULSE_NUM_BITS)
        ) u_axis (
            .clk        (clk),
            .reset      (reset),
            .i_load     (w_accept),
            .i_num      (pulse_num[g*PULSE_NUM_BITS +: PULSE_NUM_BITS]),
            .i_step     (w_step),
            .i_phase_end(w_phase_end),
            .i_major    (w_major),
            .o_mag      (w_mag[g]),
            .o_out      (w_out[g]),
            .o_dir      (w_dir[g])
        );
    end

    assign rdy       = r_rdy;
    assign done      = r_done;
    assign aborted   = r_aborted;
    assign step_cnt  = r_step_cnt;
    assign out       = w_out;
    assign dir       = w_dir;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_stepper_ctrl_multi.sv
// Bench for stepper_ctrl_multi: directed moves, expected move results queued by
// the stimulus and checked by a monitor on every rising edge of done.
module tb_stepper_ctrl_multi;
  import stepper_multi_pkg::*;

  localparam int EW = 119;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        trigger;
  logic        abort;
  logic [15:0] pulse_width;
  logic [47:0] pulse_num;
  logic        rdy, done, aborted;
  logic [15:0] step_cnt;
  logic [2:0]  out, dir;
  state_e      dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];

  stepper_ctrl_multi dut (
    .clk         (clk),
    .reset       (rst_n),
    .clk_en      (clk_en),
    .trigger     (trigger),
    .abort       (abort),
    .pulse_width (pulse_width),
    .pulse_num   (pulse_num),
    .rdy         (rdy),
    .done        (done),
    .aborted     (aborted),
    .step_cnt    (step_cnt),
    .out         (out),
    .dir         (dir),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, n_pass=%0d n_checks=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [EW-1:0] pack(input logic ab, input logic [15:0] sc, input logic [2:0] dr,
                                         input int c0, input int c1, input int c2,
                                         input logic [15:0] m0, input logic [15:0] m1, input logic [15:0] m2);
    return {ab, sc, dr, c2[16:0], c1[16:0], c0[16:0], m2, m1, m0};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_rdy(input string name);
    int k = 0;
    while (!rdy && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (!rdy) begin
      n_checks++;
      $display("FAIL %s_rdy_timeout: rdy=%0b expected 1", name, rdy);
    end
  endtask

  // Raises trigger, counts ticks (first = accepting tick) until done is seen high,
  // recording out[0] after each tick.
  task automatic run_move(input string name, input logic [15:0] p0, input logic [15:0] p1,
                          input logic [15:0] p2, input logic [15:0] pw, input int budget,
                          output int n, output logic [31:0] tr);
    pulse_num   = {p2, p1, p0};
    pulse_width = pw;
    trigger     = 1'b1;
    n  = 0;
    tr = '0;
    do begin
      @(posedge clk); #1;
      n++;
      trigger = 1'b0;
      if (n <= 32) tr[n-1] = out[0];
    end while (!done && n < budget);
    if (!done) begin
      n_checks++;
      $display("FAIL %s_done_timeout: done=%0b after %0d ticks", name, done, n);
    end
    wait_rdy(name);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [2:0]  prev_out  = 3'b000;
  logic        prev_done = 1'b1;
  int          mcnt [3];
  logic [15:0] mmask [3];
  int          mstep = 0;

  always @(negedge clk) begin
    logic [2:0]    rise;
    logic [EW-1:0] a, e;
    rise = out & ~prev_out;
    if (prev_done && !done) begin
      for (int i = 0; i < 3; i++) begin
        mcnt[i]  = 0;
        mmask[i] = '0;
      end
      mstep = 0;
    end
    if (|rise) begin
      for (int i = 0; i < 3; i++) begin
        if (rise[i]) begin
          mcnt[i]++;
          if (mstep < 16) mmask[i][mstep] = 1'b1;
        end
      end
      mstep++;
    end
    if (!prev_done && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: no expected move queued, step_cnt=%0d", step_cnt);
      end else begin
        e = exp_q.pop_front();
        a = pack(aborted, step_cnt, dir, mcnt[0], mcnt[1], mcnt[2], mmask[0], mmask[1], mmask[2]);
        check("move_status_dir", 128'(a[EW-1:99]), 128'(e[EW-1:99]));
        check("move_pulses", 128'(a[98:0]), 128'(e[98:0]));
      end
    end
    prev_out  = out;
    prev_done = done;
  end

  // ---------------- stimulus ----------------
  initial begin
    int          n;
    logic [31:0] tr;
    for (int i = 0; i < 3; i++) begin
      mcnt[i]  = 0;
      mmask[i] = '0;
    end
    rst_n       = 1'b0;
    clk_en      = 1'b1;
    trigger     = 1'b1;
    abort       = 1'b0;
    pulse_width = 16'd1;
    pulse_num   = '0;

    // Reset state with trigger held high.
    #12;
    check("reset_rdy", 128'(rdy), 128'(1));
    check("reset_done", 128'(done), 128'(1));
    check("reset_out", 128'(out), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("no_start_trigger_high_after_reset", 128'({rdy, done}), 128'(2'b11));
    trigger = 1'b0;
    @(posedge clk); #1;

    // Zero move: done low for 2 ticks, no pulses.
    exp_q.push_back(pack(1'b0, 16'd0, 3'b111, 0, 0, 0, 16'h0, 16'h0, 16'h0));
    run_move("zero", 16'd0, 16'd0, 16'd0, 16'd1, 50, n, tr);
    check("zero_move_ticks", 128'(n), 128'(2));

    // Abort during step 3 of a 10-step move (pw=2, step 3 HIGH begins at tick 10).
    exp_q.push_back(pack(1'b1, 16'd2, 3'b011, 3, 1, 0, 16'h7, 16'h2, 16'h0));
    pulse_num   = {16'hFFFD, 16'd5, 16'd10};
    pulse_width = 16'd2;
    trigger     = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    check("abort_out_cleared", 128'(out), 128'(0));
    check("abort_aborted_done_stepcnt", 128'({aborted, done, step_cnt}), 128'({1'b1, 1'b1, 16'd2}));
    abort = 1'b0;
    wait_rdy("abort");

    // Three-axis interpolation, pulse_width 0 treated as 1.
    exp_q.push_back(pack(1'b0, 16'd4, 3'b101, 4, 2, 1, 16'hF, 16'hA, 16'h8));
    run_move("interp_421", 16'd4, 16'hFFFE, 16'd1, 16'd0, 100, n, tr);
    check("interp_421_ticks", 128'(n), 128'(10));

    // clk_en high every other cycle: 6 ticks take 11 cycles.
    exp_q.push_back(pack(1'b0, 16'd2, 3'b111, 2, 1, 0, 16'h3, 16'h2, 16'h0));
    pulse_num   = {16'd0, 16'd1, 16'd2};
    pulse_width = 16'd1;
    trigger     = 1'b1;
    clk_en      = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      trigger = 1'b0;
      clk_en  = ~clk_en;
    end while (!done && n < 100);
    check("clk_en_gated_cycles", 128'(n), 128'(11));
    clk_en = 1'b1;
    wait_rdy("clk_en");

    // Reset mid-HIGH of step 2 (pw=4, step 2 HIGH spans ticks 10..13).
    exp_q.push_back(pack(1'b0, 16'd0, 3'b111, 2, 0, 0, 16'h3, 16'h0, 16'h0));
    pulse_num   = {16'd0, 16'd0, 16'd5};
    pulse_width = 16'd4;
    trigger     = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_out", 128'(out), 128'(0));
    @(posedge clk); #1;
    trigger = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("post_reset_rdy_done", 128'({rdy, done}), 128'(2'b11));
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("post_reset_no_retrigger", 128'({rdy, done}), 128'(2'b11));
    trigger = 1'b0;
    @(posedge clk); #1;

    // Single-axis move: 3 pulses, 2 high / 2 low, done 14 ticks after trigger.
    exp_q.push_back(pack(1'b0, 16'd3, 3'b111, 3, 0, 0, 16'h7, 16'h0, 16'h0));
    run_move("single_3", 16'd3, 16'd0, 16'd0, 16'd2, 100, n, tr);
    check("single_3_ticks", 128'(n), 128'(14));
    check("single_3_out0_trace", 128'(tr[13:0]), 128'(14'h0666));

    // Most negative count on axis 0: 32768 steps, accumulators must not overflow.
    exp_q.push_back(pack(1'b0, 16'h8000, 3'b010, 32768, 1, 32767, 16'hFFFF, 16'h0000, 16'hFFFE));
    run_move("max_neg", 16'h8000, 16'd1, 16'h8001, 16'd1, 70000, n, tr);
    check("max_neg_ticks", 128'(n), 128'(65538));

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
